shift_sub_divider: RTL

Sequential restoring divider for the lab arithmetic datapath. It is the inverse companion of the shift-add multiplier controller. An internal control FSM sequences load, shift and subtract/restore steps, one quotient bit per shift/subtract pair. A start/done handshake links it to the surrounding test harness or top level.

---
 rtl/shift_sub_divider.sv | 120 ++++++++++++
 1 files changed

// File: rtl/shift_sub_divider.sv
// shift_sub_divider: sequential restoring divider, one quotient bit per
// shift/subtract pair, with start/done handshake and divide-by-zero flag.
module shift_sub_divider #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         busy,
   output logic         done,
   output logic         dbz
);

   localparam int CW = $clog2(N + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_SUB   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [N:0]    r_q, r_d;
   logic [N-1:0]  q_q, q_d;
   logic [N-1:0]  d_q, d_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  quo_q, quo_d;
   logic [N-1:0]  rem_q, rem_d;
   logic          dbz_q, dbz_d;

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_LOAD;
         end
         S_LOAD: begin
            q_d   = dividend;
            d_d   = divisor;
            r_d   = '0;
            cnt_d = CW'(N);
            dbz_d = 1'b0;
            if (divisor == '0) begin
               state_d = S_DONE;
               dbz_d   = 1'b1;
               quo_d   = '1;
               rem_d   = dividend;
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            {r_d, q_d} = {r_q[N-1:0], q_q, 1'b0};
            state_d    = S_SUB;
         end
         S_SUB: begin
            // restore is implicit: R and Q keep their shifted values
            if (r_q >= {1'b0, d_q}) begin
               r_d    = r_q - {1'b0, d_q};
               q_d[0] = 1'b1;
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
               quo_d   = q_d;
               rem_d   = r_d[N-1:0];
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy      = (state_q == S_LOAD) || (state_q == S_SHIFT) ||
                      (state_q == S_SUB);
   assign done      = (state_q == S_DONE);
   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign dbz       = dbz_q;

endmodule
